reaction_session_ctrl: RTL and testbench
========================================

// Module: reaction_session_ctrl
// PURPOSE
//  Sequences a multi-trial reaction-test session on the tester core.
//  - Per trial: holds the tester's start input long enough to pass its debouncer.
//  - Waits for the trial outcome (or a timeout), then waits an inter-trial gap.
//  - Accumulates session statistics: ok/early/late counts, best, worst, sum.
//  Sits between the AXI register front-end (go/abort, stats readout) and the tester core.
// PARAMETERS
//  NUM_TRIALS     5            trials per session (>=1)
//  RES_W          9            width of reaction result in ms (matches tester res)
//  START_HOLD     1_000_000    cycles tester_start is held high (20 ms @ 50 MHz)
//  GAP_CYCLES     50_000_000   idle cycles between trials (1 s)
//  TIMEOUT_CYCLES 600_000_000  max cycles waiting for a trial outcome (12 s)
//  CNT_W = $clog2(NUM_TRIALS+1) (localparam)
// PORTS
//  clk           in  1            system clock
//  rstn          in  1            asynchronous active-low reset
//  go            in  1            1-cycle pulse: start a new session
//  abort         in  1            1-cycle pulse: terminate session
//  trial_done    in  1            1-cycle pulse: tester reported a trial outcome
//  trial_res     in  RES_W        reaction time in ms, sampled with trial_done
//  trial_status  in  2            outcome with trial_done: 00 legal, 01 early, 10 late, 11 early
//  tester_start  out 1            start level to the tester
//  busy          out 1            session in progress (any state except IDLE/DONE)
//  trial_idx     out CNT_W        trials completed this session
//  ok_cnt, early_cnt, late_cnt  out CNT_W  per-outcome counters
//  best_res      out RES_W        min legal result (all-ones if none)
//  worst_res     out RES_W        max legal result (0 if none)
//  sum_res       out RES_W+CNT_W  sum of legal results
//  session_done  out 1            1-cycle pulse when the final trial completes
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except best_res = all-ones.
//  States: IDLE, ARM, WAIT, GAP, DONE. A single down-counter (timer) serves every state.
//  IDLE/DONE + go:
//   - clear stats and trial_idx; load timer=START_HOLD-1; go to ARM.
//  ARM:
//   - tester_start=1.
//   - Timer expiry: load TIMEOUT_CYCLES-1, go to WAIT.
//  WAIT:
//   - tester_start=0.
//   - Timer expiry with no trial_done: record LATE.
//  Outcome acceptance:
//   - trial_done is accepted in ARM or WAIT only; ignored in IDLE/GAP/DONE.
//   - On acceptance: tester_start drops the next cycle; record outcome; trial_idx++.
//  Record rules:
//   - 00: ok_cnt++; sum+=res; best=min(best,res); worst=max(worst,res).
//   - 01/11: early_cnt++. 10 or timeout: late_cnt++. trial_res is ignored unless 00.
//  After recording:
//   - If trial_idx reaches NUM_TRIALS: go to DONE; session_done pulses on the same cycle the state enters DONE.
//   - Else: load GAP_CYCLES-1, go to GAP.
//  GAP:
//   - Timer expiry: load START_HOLD-1, go to ARM.
//  Simultaneous events:
//   - trial_done and timeout expiry in the same cycle: trial_done wins; one trial recorded.
//  go/abort rules:
//   - go while busy: ignored.
//   - abort: any state -> IDLE next cycle; tester_start=0; no session_done; stats and trial_idx hold.
//   - abort and go in the same cycle: abort wins.
//  Arithmetic: counters and sum_res are sized never to overflow (max NUM_TRIALS*(2^RES_W-1)).
//   - Equality test on trial_idx vs NUM_TRIALS.
//  Reset mid-session: immediate return to reset values; tester_start low asynchronously.
// STRUCTURE
//  reaction_pkg:
//   - outcome encodings ST_LEGAL=2'b00, ST_EARLY=2'b01, ST_LATE=2'b10;
//   - session state enum;
//   - shared with tester and register front-end.
//  One sub-module: cycle_timer (loadable down-counter, width $clog2(max of the three delays),
//   load/value in, expire pulse out). FSM and stats registers stay in this module.
// TESTING (bench params NUM_TRIALS=4, START_HOLD=4, GAP_CYCLES=8, TIMEOUT_CYCLES=100)
//  1. go; four legal dones res 200,150,300,250 -> ok=4, best=150, worst=300, sum=900,
//     trial_idx=4, exactly one session_done pulse, busy=0; tester_start high exactly 4 cycles per trial.
//  2. Outcomes 01, 10, 11, none -> early=2, late=2 (one via 100-cycle timeout), ok=0,
//     best=all-ones, worst=0, sum=0.
//  3. go while in WAIT -> no effect; abort in WAIT -> IDLE next cycle, tester_start=0,
//     no session_done, stats hold.
//  4. trial_done(00, res 120) on 2nd ARM cycle -> tester_start low next cycle, GAP entered, ok=1.
//  5. trial_done on the exact timeout-expiry cycle -> one trial recorded (per status), late not
//     double-counted; trial_done during GAP ignored.
//  6. rstn low mid-ARM -> all outputs to reset values at once; go afterwards runs a clean session.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction tester: outcome codes, session states, sizing helpers.
package reaction_pkg;

  localparam logic [1:0] ST_LEGAL = 2'b00;
  localparam logic [1:0] ST_EARLY = 2'b01;
  localparam logic [1:0] ST_LATE  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_GAP,
    S_DONE
  } session_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expire_c is high for the single cycle the loaded count reaches zero.
module cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire_c
);

  logic [W-1:0] cnt;
  logic         armed;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= value;
      armed <= 1'b1;
    end else if (armed) begin
      if (cnt == '0) armed <= 1'b0;
      else           cnt   <= cnt - W'(1);
    end
  end

  assign expire_c = armed && (cnt == '0);

endmodule

// File: rtl/reaction_session_ctrl.sv
// Multi-trial session sequencer for the reaction tester: arms each trial, waits for an
// outcome or timeout, spaces trials by a gap, and accumulates session statistics.
module reaction_session_ctrl
  import reaction_pkg::*;
#(
  parameter  int unsigned NUM_TRIALS     = 5,
  parameter  int unsigned RES_W          = 9,
  parameter  int unsigned START_HOLD     = 1_000_000,
  parameter  int unsigned GAP_CYCLES     = 50_000_000,
  parameter  int unsigned TIMEOUT_CYCLES = 600_000_000,
  localparam int unsigned CNT_W          = $clog2(NUM_TRIALS + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   go,
  input  logic                   abort,
  input  logic                   trial_done,
  input  logic [RES_W-1:0]       trial_res,
  input  logic [1:0]             trial_status,
  output logic                   tester_start,
  output logic                   busy,
  output logic [CNT_W-1:0]       trial_idx,
  output logic [CNT_W-1:0]       ok_cnt,
  output logic [CNT_W-1:0]       early_cnt,
  output logic [CNT_W-1:0]       late_cnt,
  output logic [RES_W-1:0]       best_res,
  output logic [RES_W-1:0]       worst_res,
  output logic [RES_W+CNT_W-1:0] sum_res,
  output logic                   session_done
);

  localparam int unsigned SUM_W = RES_W + CNT_W;
  localparam int unsigned TMR_W = bits_for(max3(START_HOLD, GAP_CYCLES, TIMEOUT_CYCLES));

  session_state_e   state;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_expire;
  logic             start_go, accept, timeout, arm_exp, gap_exp, record, last;
  logic             is_ok, is_early, is_late;

  cycle_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .value    (tmr_value),
    .expire_c (tmr_expire)
  );

  // Event decode and timer reload; abort masks everything, trial_done beats a timer expiry.
  always_comb begin
    start_go  = go && !abort && ((state == S_IDLE) || (state == S_DONE));
    accept    = trial_done && !abort && ((state == S_ARM) || (state == S_WAIT));
    timeout   = tmr_expire && !abort && !trial_done && (state == S_WAIT);
    arm_exp   = tmr_expire && !abort && !trial_done && (state == S_ARM);
    gap_exp   = tmr_expire && !abort && (state == S_GAP);
    record    = accept || timeout;
    last      = record && ((trial_idx + CNT_W'(1)) == CNT_W'(NUM_TRIALS));
    is_ok     = accept && (trial_status == ST_LEGAL);
    is_late   = timeout || (accept && (trial_status == ST_LATE));
    is_early  = accept && !is_ok && !is_late;
    tmr_load  = 1'b0;
    tmr_value = '0;
    if (start_go || gap_exp) begin
      tmr_load  = 1'b1;
      tmr_value = TMR_W'(START_HOLD - 1);
    end else if (arm_exp) begin
      tmr_load  = 1'b1;
      tmr_value = TMR_W'(TIMEOUT_CYCLES - 1);
    end else if (record && !last) begin
      tmr_load  = 1'b1;
      tmr_value = TMR_W'(GAP_CYCLES - 1);
    end
  end

  // Session FSM with registered outputs and statistics.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      tester_start <= 1'b0;
      busy         <= 1'b0;
      trial_idx    <= '0;
      ok_cnt       <= '0;
      early_cnt    <= '0;
      late_cnt     <= '0;
      best_res     <= '1;
      worst_res    <= '0;
      sum_res      <= '0;
      session_done <= 1'b0;
    end else begin
      session_done <= 1'b0;
      if (abort) begin
        state        <= S_IDLE;
        tester_start <= 1'b0;
        busy         <= 1'b0;
      end else if (start_go) begin
        state        <= S_ARM;
        tester_start <= 1'b1;
        busy         <= 1'b1;
        trial_idx    <= '0;
        ok_cnt       <= '0;
        early_cnt    <= '0;
        late_cnt     <= '0;
        best_res     <= '1;
        worst_res    <= '0;
        sum_res      <= '0;
      end else if (record) begin
        tester_start <= 1'b0;
        trial_idx    <= trial_idx + CNT_W'(1);
        if (is_ok) begin
          ok_cnt  <= ok_cnt + CNT_W'(1);
          sum_res <= sum_res + SUM_W'(trial_res);
          if (trial_res < best_res)  best_res  <= trial_res;
          if (trial_res > worst_res) worst_res <= trial_res;
        end
        if (is_early) early_cnt <= early_cnt + CNT_W'(1);
        if (is_late)  late_cnt  <= late_cnt + CNT_W'(1);
        if (last) begin
          state        <= S_DONE;
          busy         <= 1'b0;
          session_done <= 1'b1;
        end else begin
          state <= S_GAP;
        end
      end else if (arm_exp) begin
        state        <= S_WAIT;
        tester_start <= 1'b0;
      end else if (gap_exp) begin
        state        <= S_ARM;
        tester_start <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Directed and randomized bench for reaction_session_ctrl against a trial-list model.
module tb_reaction_session_ctrl;

  localparam int unsigned NT   = 4;
  localparam int unsigned RW   = 9;
  localparam int unsigned SH   = 4;
  localparam int unsigned GC   = 8;
  localparam int unsigned TO   = 100;
  localparam int unsigned CW   = $clog2(NT + 1);
  localparam int          ALL1 = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic          trial_done = 1'b0;
  logic [RW-1:0] trial_res = '0;
  logic [1:0]    trial_status = '0;
  logic          tester_start, busy, session_done;
  logic [CW-1:0] trial_idx, ok_cnt, early_cnt, late_cnt;
  logic [RW-1:0] best_res, worst_res;
  logic [RW+CW-1:0] sum_res;

  int checks = 0;
  int errors = 0;
  int sd_pulses = 0;
  int sd_base = 0;
  // Model: kind per recorded trial (0 legal, 1 early 01, 2 late 10, 3 early 11, 4 timeout)
  int q_kind[$];
  int q_res[$];

  reaction_session_ctrl #(
    .NUM_TRIALS(NT), .RES_W(RW), .START_HOLD(SH), .GAP_CYCLES(GC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .go(go), .abort(abort), .trial_done(trial_done),
    .trial_res(trial_res), .trial_status(trial_status), .tester_start(tester_start),
    .busy(busy), .trial_idx(trial_idx), .ok_cnt(ok_cnt), .early_cnt(early_cnt),
    .late_cnt(late_cnt), .best_res(best_res), .worst_res(worst_res), .sum_res(sum_res),
    .session_done(session_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (session_done === 1'b1) sd_pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] status_of(input int kind);
    case (kind)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Expected statistics recomputed from the whole list of recorded trials.
  task automatic check_stats(input string tag);
    int ok = 0, ea = 0, la = 0, best = ALL1, worst = 0, sum = 0;
    foreach (q_kind[i]) begin
      case (q_kind[i])
        0: begin
          ok++;
          sum += q_res[i];
          if (q_res[i] < best)  best  = q_res[i];
          if (q_res[i] > worst) worst = q_res[i];
        end
        1, 3:    ea++;
        default: la++;
      endcase
    end
    chk({tag, ".idx"},   64'(trial_idx), 64'(q_kind.size()));
    chk({tag, ".ok"},    64'(ok_cnt),    64'(ok));
    chk({tag, ".early"}, 64'(early_cnt), 64'(ea));
    chk({tag, ".late"},  64'(late_cnt),  64'(la));
    chk({tag, ".best"},  64'(best_res),  64'(best));
    chk({tag, ".worst"}, 64'(worst_res), 64'(worst));
    chk({tag, ".sum"},   64'(sum_res),   64'(sum));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".ts"},    64'(tester_start), 64'(0));
    chk({tag, ".busy"},  64'(busy),         64'(0));
    chk({tag, ".sdone"}, 64'(session_done), 64'(0));
    q_kind.delete();
    q_res.delete();
    check_stats(tag);
  endtask

  task automatic start_session();
    q_kind.delete();
    q_res.delete();
    sd_base = sd_pulses;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("go.ts", 64'(tester_start), 64'(1));
    chk("go.busy", 64'(busy), 64'(1));
    check_stats("go");
  endtask

  task automatic pulse_done(input int kind, input int res);
    trial_status = status_of(kind);
    trial_res    = RW'(res);
    trial_done   = 1'b1;
    tick();
    trial_done   = 1'b0;
    trial_status = 2'($urandom);
    trial_res    = RW'($urandom);
  endtask

  // After a trial is recorded: either the session ends, or the gap precedes the next arm.
  task automatic post_record(input int gap_start);
    int g = gap_start;
    if (q_kind.size() == NT) begin
      chk("end.sdone_hi", 64'(session_done), 64'(1));
      chk("end.busy", 64'(busy), 64'(0));
      tick();
      chk("end.sdone_lo", 64'(session_done), 64'(0));
      tick();
      chk("end.sdone_cnt", 64'(sd_pulses - sd_base), 64'(1));
    end else begin
      chk("gap.busy", 64'(busy), 64'(1));
      while (tester_start !== 1'b1 && g < 50) begin
        tick();
        g++;
      end
      chk("gap.len", 64'(g), 64'(GC));
    end
  endtask

  task automatic measure_arm();
    int hi = 0;
    while (tester_start === 1'b1 && hi < 20) begin
      tick();
      hi++;
    end
    chk("arm.len", 64'(hi), 64'(SH));
  endtask

  // Entered with tester_start just risen; runs one trial to its recorded outcome.
  task automatic run_trial(input int kind, input int res, input int dly);
    int n = 0;
    logic [CW-1:0] old;
    measure_arm();
    if (kind == 4) begin
      old = trial_idx;
      while (trial_idx === old && n < 200) begin
        tick();
        n++;
      end
      chk("wait.timeout_len", 64'(n), 64'(TO));
      q_kind.push_back(4);
      q_res.push_back(0);
    end else begin
      repeat (dly - 1) tick();
      pulse_done(kind, res);
      q_kind.push_back(kind);
      q_res.push_back(res);
    end
    chk("rec.ts", 64'(tester_start), 64'(0));
    check_stats("rec");
    post_record(0);
  endtask

  task automatic random_session();
    start_session();
    for (int t = 0; t < int'(NT); t++)
      run_trial(int'($urandom_range(0, 4)), int'($urandom_range(0, ALL1)),
                int'($urandom_range(1, 30)));
  endtask

  initial begin
    int g;
    int k;
    repeat (2) tick();
    check_reset_vals("reset");
    rstn = 1'b1;
    tick();
    check_reset_vals("post_reset");

    // Four legal trials with fixed results.
    start_session();
    run_trial(0, 200, int'($urandom_range(1, 30)));
    run_trial(0, 150, int'($urandom_range(1, 30)));
    run_trial(0, 300, int'($urandom_range(1, 30)));
    run_trial(0, 250, int'($urandom_range(1, 30)));

    // Early, late, early(11), timeout.
    start_session();
    run_trial(1, int'($urandom_range(0, ALL1)), int'($urandom_range(1, 30)));
    run_trial(2, int'($urandom_range(0, ALL1)), int'($urandom_range(1, 30)));
    run_trial(3, int'($urandom_range(0, ALL1)), int'($urandom_range(1, 30)));
    run_trial(4, 0, 1);

    // go ignored while busy; abort returns to IDLE keeping stats.
    start_session();
    run_trial(0, int'($urandom_range(0, ALL1)), int'($urandom_range(1, 30)));
    measure_arm();
    repeat (3) tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("busy_go.busy", 64'(busy), 64'(1));
    chk("busy_go.ts", 64'(tester_start), 64'(0));
    check_stats("busy_go");
    repeat (2) tick();
    abort = 1'b1;
    go = 1'b1;
    tick();
    abort = 1'b0;
    go = 1'b0;
    chk("abort.busy", 64'(busy), 64'(0));
    chk("abort.ts", 64'(tester_start), 64'(0));
    pulse_done(0, 77);
    repeat (TO + 20) tick();
    chk("abort.ts_later", 64'(tester_start), 64'(0));
    chk("abort.no_sdone", 64'(sd_pulses - sd_base), 64'(0));
    check_stats("abort");

    // trial_done on the second ARM cycle, then trial_done on the timeout-expiry cycle.
    start_session();
    tick();
    pulse_done(0, 120);
    q_kind.push_back(0);
    q_res.push_back(120);
    chk("early_arm.ts", 64'(tester_start), 64'(0));
    check_stats("early_arm");
    post_record(0);
    measure_arm();
    repeat (TO - 1) tick();
    k = int'($urandom_range(0, 1));
    g = int'($urandom_range(0, ALL1));
    pulse_done(k, g);
    q_kind.push_back(k);
    q_res.push_back(g);
    check_stats("tie");
    pulse_done(0, 5);
    check_stats("gap_done_ignored");
    post_record(1);
    run_trial(int'($urandom_range(0, 4)), int'($urandom_range(0, ALL1)), int'($urandom_range(1, 30)));
    run_trial(int'($urandom_range(0, 4)), int'($urandom_range(0, ALL1)), int'($urandom_range(1, 30)));

    // Asynchronous reset in the middle of ARM.
    start_session();
    run_trial(0, int'($urandom_range(1, ALL1 - 1)), int'($urandom_range(1, 30)));
    tick();
    #2 rstn = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    tick();
    rstn = 1'b1;
    tick();
    check_reset_vals("after_reset");

    // Clean randomized sessions after reset.
    repeat (3) random_session();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
